demo_ctrl_multi: RTL
====================

DEMO_CTRL_MULTI -- requirements
Module: demo_ctrl_multi

Interface
REQ-001 SHALL have parameter NCH, default 2, number of user channels (1..8).
REQ-002 SHALL have parameter ADDR_W, default 12, bus address width.
REQ-003 SHALL have parameter DATA_W, default 8, bus data width and per-channel LED width.
REQ-004 SHALL have parameter DEB_CYCLES, default 16, consecutive low samples needed to accept a button press.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum cycles from request acceptance to read response.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 start_n  in  NCH  asynchronous active-low push-buttons, one per channel.
REQ-010 mode  in  NCH  per-channel operation select: 1 = write, 0 = read.
REQ-011 ready  out  NCH  1 = channel idle and able to accept a press.
REQ-012 err  out  NCH  sticky read-timeout flag per channel.
REQ-013 led  out  NCH*DATA_W  channel c display in bits [c*DATA_W +: DATA_W].
REQ-014 req_valid / req_ready  out / in  1 / 1  bus request handshake.
REQ-015 req_write  out  1  1 = write, 0 = read.
REQ-016 req_addr  out  ADDR_W  target address, equal to the granted channel index zero-extended.
REQ-017 req_wdata  out  DATA_W  write data.
REQ-018 rsp_valid / rsp_rdata  in  1 / DATA_W  read response strobe and data.

Function
REQ-019 SHALL pass each start_n bit through a 2-FF synchroniser, then a debouncer that asserts "pressed" after DEB_CYCLES consecutive synchronised low samples and releases after DEB_CYCLES consecutive high samples.
REQ-020 SHALL generate exactly one press event per debounced high-to-low transition; holding the button SHALL NOT generate further events.
REQ-021 Each channel FSM SHALL have states IDLE, PEND, ISSUE and RESP; ready = 1 only in IDLE.
REQ-022 On a press event in IDLE, the channel SHALL latch mode, clear err, and move to PEND; a press event in any other state SHALL be ignored.
REQ-023 A single round-robin arbiter SHALL grant one PEND channel whenever no transaction is outstanding, searching from the channel after the last granted one; the granted channel moves to ISSUE.
REQ-024 In ISSUE, req_valid SHALL be 1, with req_write, req_addr and req_wdata held stable until the cycle in which req_valid and req_ready are both 1.
REQ-025 After a write handshake, led[c] SHALL take the value written and the channel SHALL return to IDLE in the next cycle.
REQ-026 Write data SHALL come from a per-channel DATA_W counter, reset value 1, incremented after each accepted write and wrapping from all-ones to 0.
REQ-027 After a read handshake, the channel SHALL enter RESP; on rsp_valid, led[c] SHALL take rsp_rdata and the channel SHALL return to IDLE.
REQ-028 RESP SHALL count cycles; if TIMEOUT cycles elapse without rsp_valid, the channel SHALL set err[c], leave led[c] unchanged and return to IDLE.
REQ-029 Exactly one transaction SHALL be outstanding at any time; rsp_valid outside RESP SHALL be ignored.
REQ-030 Press events arriving on several channels in the same cycle SHALL all be latched into PEND and then served in round-robin order.
REQ-031 req_valid SHALL be driven from a register, with no combinational path from req_ready.

Reset
REQ-032 While rst is 1, the block SHALL drive: all channel FSMs IDLE, ready all ones, err 0, led 0, req_valid 0, req_write 0, req_addr 0, req_wdata 0, write counters 1, round-robin pointer to channel 0, and debouncers reading "released".
REQ-033 Reset asserted mid-transaction SHALL abort the transaction with no further req_valid, and any response arriving afterwards SHALL be ignored.

Verification
REQ-034 Reset, then hold start_n[0] low for DEB_CYCLES+4 cycles with mode[0]=1 and req_ready=1 -> one write to addr 0 with wdata 0x01, led[0]=0x01, ready[0] returns to 1; holding the button longer produces no second write.
REQ-035 A 5-cycle glitch low on start_n[1] with DEB_CYCLES=16 -> no request; ready[1] stays 1.
REQ-036 Press both channels in the same cycle, both mode=1, after one prior grant to channel 0 -> channel 1 is served first, then channel 0; req_ready held 0 for 3 cycles keeps the payload stable.
REQ-037 Channel 0 read, with the responder returning rsp_rdata=0xA5 three cycles after the handshake -> led[0]=0xA5, err[0]=0.
REQ-038 Channel 1 read with no response -> after TIMEOUT cycles err[1]=1, led[1] unchanged, ready[1]=1; the next press clears err[1].
REQ-039 Drive 256 writes on channel 0 with DATA_W=8 -> wdata sequence 0x01..0xFF then 0x00 (wrap), then assert rst during a later ISSUE -> req_valid drops to 0 the following cycle and all outputs hold their reset values.

Source files
------------

// File: rtl/demo_ctrl_multi.sv
// demo_ctrl_multi: per-channel push-button front end (synchroniser, debouncer,
// edge detector) feeding small channel FSMs that share one bus master through
// a round-robin arbiter. Only one bus transaction is outstanding at a time.
module demo_ctrl_multi #(
  parameter int NCH        = 2,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int DEB_CYCLES = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        start_n,
  input  logic [NCH-1:0]        mode,
  output logic [NCH-1:0]        ready,
  output logic [NCH-1:0]        err,
  output logic [NCH*DATA_W-1:0] led,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [ADDR_W-1:0]     req_addr,
  output logic [DATA_W-1:0]     req_wdata,
  input  logic                  rsp_valid,
  input  logic [DATA_W-1:0]     rsp_rdata
);

  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Button front end
  logic [NCH-1:0]    sync1;
  logic [NCH-1:0]    sync2;
  logic [NCH-1:0]    deb;        // 1 = debounced "pressed"
  logic [NCH-1:0]    deb_prev;
  logic [NCH-1:0]    press_ev;
  logic [DCW-1:0]    deb_cnt [NCH];

  // Channel state
  state_t            state_q [NCH];
  state_t            state_d [NCH];
  logic [NCH-1:0]    mode_q;
  logic [DATA_W-1:0] wcnt [NCH];

  // Arbiter / bus bookkeeping
  logic [PW-1:0]     rr_ptr;     // first channel to consider at the next grant
  logic [TW-1:0]     timer;
  logic              outstanding;
  logic              in_resp;
  logic              grant_any;
  logic [PW-1:0]     grant_idx;
  logic              hs;
  logic              tmo_hit;
  int                idx;

  // Synchronise the raw buttons and debounce: the level flips only after
  // DEB_CYCLES consecutive samples that disagree with the current level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '1;
      sync2    <= '1;
      deb      <= '0;
      deb_prev <= '0;
      for (int c = 0; c < NCH; c++) begin
        deb_cnt[c] <= '0;
      end
    end else begin
      sync1    <= start_n;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int c = 0; c < NCH; c++) begin
        // sample high while pressed, or low while released, is a disagreement
        if (sync2[c] == deb[c]) begin
          if (deb_cnt[c] == DCW'(DEB_CYCLES - 1)) begin
            deb[c]     <= ~deb[c];
            deb_cnt[c] <= '0;
          end else begin
            deb_cnt[c] <= deb_cnt[c] + DCW'(1);
          end
        end else begin
          deb_cnt[c] <= '0;
        end
      end
    end
  end

  // One event per debounced press; holding the button keeps deb high.
  assign press_ev = deb & ~deb_prev;

  // Arbitration and per-channel next-state logic.
  always_comb begin
    hs          = req_valid & req_ready;
    outstanding = 1'b0;
    in_resp     = 1'b0;
    grant_any   = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int c = 0; c < NCH; c++) begin
      outstanding = outstanding | (state_q[c] == ISSUE) | (state_q[c] == RESP);
      in_resp     = in_resp | (state_q[c] == RESP);
    end
    tmo_hit = in_resp & ~rsp_valid & (timer == TW'(TIMEOUT - 1));
    // search starts at rr_ptr, which points just past the last grant
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!outstanding && !grant_any && (state_q[idx] == PEND)) begin
        grant_any = 1'b1;
        grant_idx = PW'(idx);
      end else begin
        grant_any = grant_any;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        IDLE: begin
          if (press_ev[c]) state_d[c] = PEND;
          else             state_d[c] = IDLE;
        end
        PEND: begin
          if (grant_any && (grant_idx == PW'(c))) state_d[c] = ISSUE;
          else                                    state_d[c] = PEND;
        end
        ISSUE: begin
          if (hs) state_d[c] = mode_q[c] ? IDLE : RESP;
          else    state_d[c] = ISSUE;
        end
        RESP: begin
          if (rsp_valid || tmo_hit) state_d[c] = IDLE;
          else                      state_d[c] = RESP;
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  // Channel registers: state, latched mode, write counter, LEDs, flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      ready  <= '1;
      err    <= '0;
      led    <= '0;
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= IDLE;
        wcnt[c]    <= DATA_W'(1);
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        ready[c]   <= (state_d[c] == IDLE);
        if ((state_q[c] == IDLE) && press_ev[c]) begin
          mode_q[c] <= mode[c];
          err[c]    <= 1'b0;
        end
        if ((state_q[c] == ISSUE) && hs && mode_q[c]) begin
          led[c*DATA_W +: DATA_W] <= req_wdata;
          wcnt[c]                 <= wcnt[c] + DATA_W'(1);
        end
        if ((state_q[c] == RESP) && rsp_valid) begin
          led[c*DATA_W +: DATA_W] <= rsp_rdata;
        end
        if ((state_q[c] == RESP) && tmo_hit) begin
          err[c] <= 1'b1;
        end
      end
    end
  end

  // Bus master: payload loaded at grant and held until the handshake;
  // req_valid is a flop so req_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      rr_ptr    <= '0;
      timer     <= '0;
    end else begin
      if (grant_any) begin
        req_valid <= 1'b1;
        req_write <= mode_q[grant_idx];
        req_addr  <= ADDR_W'(grant_idx);
        req_wdata <= wcnt[grant_idx];
        rr_ptr    <= (grant_idx == PW'(NCH - 1)) ? PW'(0) : grant_idx + PW'(1);
      end else if (hs) begin
        req_valid <= 1'b0;
      end
      if (hs) begin
        timer <= '0;
      end else if (in_resp) begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule
